// File: rtl/mitchell_stats_pkg.sv
// Shared types, default widths and width helpers for the Mitchell error-statistics engine.
package mitchell_stats_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DIV  = 2'd2,
        S_ACC  = 2'd3
    } state_t;

    localparam int DEF_IN_W  = 9;
    localparam int DEF_P_W   = 17;
    localparam int DEF_FRAC  = 16;
    localparam int DEF_CNT_W = 32;
    localparam int DEF_ACC_W = 64;

    // Quotient width: the error distance is shifted up by FRAC bits before division.
    function automatic int calc_q_w(input int p_w, input int frac);
        return p_w + frac;
    endfunction

endpackage

// File: rtl/restoring_div.sv
// Unsigned restoring divider, one quotient bit per cycle, N_W iterations after i_start.
// o_done is high during the final iteration; o_quot holds the full quotient from the
// following cycle until the next i_start.
module restoring_div #(
    parameter int N_W = 33,
    parameter int D_W = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clear,
    input  logic           i_start,
    input  logic [N_W-1:0] i_dividend,
    input  logic [D_W-1:0] i_divisor,
    output logic           o_done,
    output logic [N_W-1:0] o_quot
);

    localparam int CW = (N_W > 1) ? $clog2(N_W) : 1;

    logic           r_active;
    logic [CW-1:0]  r_cnt;
    logic [D_W-1:0] r_rem;
    logic [D_W-1:0] r_div;
    logic [N_W-1:0] r_quo;   // dividend bits shift out of the top, quotient bits in at the bottom

    logic [D_W:0]   w_trial;
    logic [D_W:0]   w_diff;
    logic           w_bit;
    logic           w_last;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        w_trial = {r_rem, r_quo[N_W-1]};
        w_diff  = w_trial - {1'b0, r_div};
        w_bit   = (w_trial >= {1'b0, r_div});
        w_last  = r_active && (r_cnt == CW'(N_W - 1));
    end

    // Iteration state; a clear aborts any division in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state is written with <= so every register samples pre-edge values.
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
        end else if (i_clear) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_quo    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_div    <= i_divisor;
            r_quo    <= i_dividend;
        end else if (r_active) begin
            r_rem    <= w_bit ? w_diff[D_W-1:0] : w_trial[D_W-1:0];
            r_quo    <= {r_quo[N_W-2:0], w_bit};
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_active <= 1'b0;
            end
        end
    end

    assign o_done = w_last;
    assign o_quot = r_quo;

endmodule

// File: rtl/mitchell_err_stats.sv
// Error-statistics engine for the Mitchell approximate multiplier: exact product, error
// distance, saturating sums and a fixed-point relative-error accumulator.
module mitchell_err_stats
    import mitchell_stats_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int P_W   = DEF_P_W,
    parameter int FRAC  = DEF_FRAC,
    parameter int CNT_W = DEF_CNT_W,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_x,
    input  logic [IN_W-1:0]  in_y,
    input  logic [P_W-1:0]   in_p,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] valid_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] sum_ed,
    output logic [P_W-1:0]   max_ed,
    output logic [ACC_W-1:0] sum_red,
    output logic             ovf,
    output logic             busy
);

    localparam int Q_W = calc_q_w(P_W, FRAC);
    localparam int SW  = ((ACC_W > Q_W) ? ACC_W : Q_W) + 1;   // sum width wide enough to see overflow
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ACC_W-1:0] ACC_MAX = '1;

    state_t           r_state;
    state_t           w_state_nx;
    logic [IN_W-1:0]  r_x;
    logic [IN_W-1:0]  r_y;
    logic [P_W-1:0]   r_p;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_valid_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [ACC_W-1:0] r_sum_ed;
    logic [P_W-1:0]   r_max_ed;
    logic [ACC_W-1:0] r_sum_red;
    logic             r_ovf;

    logic [P_W-1:0]   w_exact;
    logic [P_W-1:0]   w_ed;
    logic             w_div_start;
    logic             w_div_done;
    logic [Q_W-1:0]   w_quot;
    logic [SW-1:0]    w_sum_ed_wide;
    logic [SW-1:0]    w_sum_red_wide;
    logic             w_sum_ed_sat;
    logic             w_sum_red_sat;
    logic             w_calc_ovf;

    // Exact (truncated) product, error distance and saturating sums for the latched sample.
    always_comb begin
        w_exact        = P_W'(r_x * r_y);
        w_ed           = (r_p >= w_exact) ? (r_p - w_exact) : (w_exact - r_p);
        w_sum_ed_wide  = SW'(r_sum_ed) + SW'(w_ed);
        w_sum_red_wide = SW'(r_sum_red) + SW'(w_quot);
        w_sum_ed_sat   = (w_sum_ed_wide > SW'(ACC_MAX));
        w_sum_red_sat  = (w_sum_red_wide > SW'(ACC_MAX));
        w_calc_ovf     = (r_sample_cnt == CNT_MAX)
                       | ((w_ed != '0) && (r_err_cnt == CNT_MAX))
                       | ((w_exact != '0) && (r_valid_cnt == CNT_MAX))
                       | w_sum_ed_sat;
        w_div_start    = (r_state == S_CALC) && !clear && (w_exact != '0) && (w_ed != '0);
    end

    restoring_div #(
        .N_W (Q_W),
        .D_W (P_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (clear),
        .i_start    (w_div_start),
        .i_dividend ({w_ed, {FRAC{1'b0}}}),
        .i_divisor  (w_exact),
        .o_done     (w_div_done),
        .o_quot     (w_quot)
    );

    // Next-state logic; clear wins from any state.
    always_comb begin
        // NOTE: a default on entry keeps this block purely combinational (no latch).
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: if (in_valid && in_ready) w_state_nx = S_CALC;
            S_CALC: w_state_nx = ((w_exact == '0) || (w_ed == '0)) ? S_IDLE : S_DIV;
            S_DIV:  if (w_div_done) w_state_nx = S_ACC;
            S_ACC:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (clear) begin
            w_state_nx = S_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Sample capture on the accept handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
            r_p <= '0;
        end else if (in_valid && in_ready) begin
            r_x <= in_x;
            r_y <= in_y;
            r_p <= in_p;
        end
    end

    // Statistics: per-sample sums in CALC, relative error in ACC, all saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_valid_cnt  <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_max_ed     <= '0;
            r_sum_red    <= '0;
            r_ovf        <= 1'b0;
        end else if (clear) begin
            r_sample_cnt <= '0;
            r_valid_cnt  <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_max_ed     <= '0;
            r_sum_red    <= '0;
            r_ovf        <= 1'b0;
        end else if (r_state == S_CALC) begin
            if (r_sample_cnt != CNT_MAX) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if ((w_exact != '0) && (r_valid_cnt != CNT_MAX)) r_valid_cnt <= r_valid_cnt + CNT_W'(1);
            if ((w_ed != '0) && (r_err_cnt != CNT_MAX)) r_err_cnt <= r_err_cnt + CNT_W'(1);
            r_sum_ed <= w_sum_ed_sat ? ACC_MAX : w_sum_ed_wide[ACC_W-1:0];
            if (w_ed > r_max_ed) r_max_ed <= w_ed;
            if (w_calc_ovf) r_ovf <= 1'b1;
        end else if (r_state == S_ACC) begin
            r_sum_red <= w_sum_red_sat ? ACC_MAX : w_sum_red_wide[ACC_W-1:0];
            if (w_sum_red_sat) r_ovf <= 1'b1;
        end
    end

    assign in_ready   = (r_state == S_IDLE) && !clear;
    assign busy       = (r_state != S_IDLE);
    assign sample_cnt = r_sample_cnt;
    assign valid_cnt  = r_valid_cnt;
    assign err_cnt    = r_err_cnt;
    assign sum_ed     = r_sum_ed;
    assign max_ed     = r_max_ed;
    assign sum_red    = r_sum_red;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_mitchell_err_stats.sv
// Directed bench: table of cumulative expectations plus hand sequences for held valid,
// clear and reset mid-division, and saturation on a narrow-width instance.
module tb_mitchell_err_stats;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    // Default-width instance
    logic        a_valid = 1'b0;
    logic [8:0]  a_x = '0, a_y = '0;
    logic [16:0] a_p = '0;
    logic        a_ready, a_ovf, a_busy;
    logic [31:0] a_sample, a_vcnt, a_ecnt;
    logic [63:0] a_sum_ed, a_sum_red;
    logic [16:0] a_max_ed;

    // Narrow-counter instance for saturation
    logic        b_valid = 1'b0;
    logic [8:0]  b_x = '0, b_y = '0;
    logic [16:0] b_p = '0;
    logic        b_ready, b_ovf, b_busy;
    logic [1:0]  b_sample, b_vcnt, b_ecnt;
    logic [11:0] b_sum_ed, b_sum_red;
    logic [16:0] b_max_ed;

    mitchell_err_stats dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(a_valid), .in_ready(a_ready),
        .in_x(a_x), .in_y(a_y), .in_p(a_p), .sample_cnt(a_sample), .valid_cnt(a_vcnt),
        .err_cnt(a_ecnt), .sum_ed(a_sum_ed), .max_ed(a_max_ed), .sum_red(a_sum_red),
        .ovf(a_ovf), .busy(a_busy)
    );

    mitchell_err_stats #(.CNT_W(2), .ACC_W(12)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(b_valid), .in_ready(b_ready),
        .in_x(b_x), .in_y(b_y), .in_p(b_p), .sample_cnt(b_sample), .valid_cnt(b_vcnt),
        .err_cnt(b_ecnt), .sum_ed(b_sum_ed), .max_ed(b_max_ed), .sum_red(b_sum_red),
        .ovf(b_ovf), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [16:0] p;
        int          lat;
        longint      sample;
        longint      vcnt;
        longint      ecnt;
        longint      sum_ed;
        longint      max_ed;
        longint      sum_red;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic ready_of(input int which);
        return (which == 0) ? a_ready : b_ready;
    endfunction

    // Offer one sample, then count negedges from the accept edge until in_ready returns.
    task automatic send(input int which, input logic [8:0] x, input logic [8:0] y,
                        input logic [16:0] p, output int lat);
        int n;
        lat = -1;
        @(negedge clk);
        n = 0;
        while (!ready_of(which) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (which == 0) begin
            a_x = x; a_y = y; a_p = p; a_valid = 1'b1;
        end else begin
            b_x = x; b_y = y; b_p = p; b_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready_of(which) && n < 100);
        if (ready_of(which)) lat = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;

        // Cumulative expectations for the default instance.
        vecs[0] = '{9'd10,  9'd10,  17'd100,    2,  1, 1, 0,    0,   0,    0};
        vecs[1] = '{9'd3,   9'd5,   17'd14,    36,  2, 2, 1,    1,   1, 4369};
        vecs[2] = '{9'd255, 9'd255, 17'd66000, 36,  3, 3, 2,  976, 975, 5351};
        vecs[3] = '{9'd0,   9'd200, 17'd3,      2,  4, 3, 3,  979, 975, 5351};
        vecs[4] = '{9'd511, 9'd511, 17'd130049, 2,  5, 4, 3,  979, 975, 5351};
        vecs[5] = '{9'd511, 9'd511, 17'd130050, 36, 6, 5, 4,  980, 975, 5351};
        vecs[6] = '{9'd255, 9'd255, 17'd64050, 36,  7, 6, 5, 1955, 975, 6333};
        vecs[7] = '{9'd0,   9'd0,   17'd0,      2,  8, 6, 5, 1955, 975, 6333};

        // Reset applied with no clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst_sample_cnt", a_sample, 0);
        check("rst_valid_cnt",  a_vcnt,   0);
        check("rst_err_cnt",    a_ecnt,   0);
        check("rst_sum_ed",     a_sum_ed, 0);
        check("rst_max_ed",     a_max_ed, 0);
        check("rst_sum_red",    a_sum_red, 0);
        check("rst_ovf",        a_ovf,    0);
        check("rst_busy",       a_busy,   0);
        check("rst_in_ready",   a_ready,  1);
        check("rst_s_ovf",      b_ovf,    0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven samples.
        for (int i = 0; i < 8; i++) begin
            send(0, vecs[i].x, vecs[i].y, vecs[i].p, lat);
            check($sformatf("v%0d_latency", i),  lat,       vecs[i].lat);
            check($sformatf("v%0d_sample", i),   a_sample,  vecs[i].sample);
            check($sformatf("v%0d_valid", i),    a_vcnt,    vecs[i].vcnt);
            check($sformatf("v%0d_err", i),      a_ecnt,    vecs[i].ecnt);
            check($sformatf("v%0d_sum_ed", i),   a_sum_ed,  vecs[i].sum_ed);
            check($sformatf("v%0d_max_ed", i),   a_max_ed,  vecs[i].max_ed);
            check($sformatf("v%0d_sum_red", i),  a_sum_red, vecs[i].sum_red);
            check($sformatf("v%0d_ovf", i),      a_ovf,     0);
        end

        // in_valid held high for 20 edges on the fast path: 10 accepts.
        @(negedge clk);
        a_x = 9'd511; a_y = 9'd511; a_p = 17'd130049; a_valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 a_valid = 1'b0;
        @(negedge clk);
        check("hold_sample", a_sample, 18);
        check("hold_valid",  a_vcnt,   16);
        check("hold_err",    a_ecnt,   5);
        check("hold_sum_ed", a_sum_ed, 1955);
        check("hold_busy",   a_busy,   0);

        // Saturation on the narrow instance.
        send(1, 9'd0, 9'd0, 17'd131071, lat);
        check("sat_latency", lat,      2);
        check("sat_sum_ed",  b_sum_ed, 4095);
        check("sat_ovf",     b_ovf,    1);
        check("sat_max_ed",  b_max_ed, 131071);
        check("sat_valid",   b_vcnt,   0);
        repeat (3) send(1, 9'd10, 9'd10, 17'd100, lat);
        check("sat_sample",  b_sample, 3);
        check("sat_sum_ed2", b_sum_ed, 4095);
        check("sat_ovf2",    b_ovf,    1);

        // clear during DIV cycle 10.
        @(negedge clk);
        a_x = 9'd3; a_y = 9'd5; a_p = 17'd14; a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("clr_busy_before", a_busy, 1);
        clear = 1'b1;
        #1;
        check("clr_in_ready_low", a_ready, 0);
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        check("clr_sample",  a_sample,  0);
        check("clr_valid",   a_vcnt,    0);
        check("clr_err",     a_ecnt,    0);
        check("clr_sum_ed",  a_sum_ed,  0);
        check("clr_max_ed",  a_max_ed,  0);
        check("clr_sum_red", a_sum_red, 0);
        check("clr_busy",    a_busy,    0);
        check("clr_ready",   a_ready,   1);
        check("clr_s_ovf",   b_ovf,     0);
        check("clr_s_sum_ed", b_sum_ed, 0);
        send(0, 9'd2, 9'd2, 17'd3, lat);
        check("post_clr_latency", lat,       36);
        check("post_clr_sample",  a_sample,  1);
        check("post_clr_sum_ed",  a_sum_ed,  1);
        check("post_clr_sum_red", a_sum_red, 16384);

        // Asynchronous reset during DIV cycle 10.
        @(negedge clk);
        a_x = 9'd255; a_y = 9'd255; a_p = 17'd66000; a_valid = 1'b1;
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("arst_busy_before", a_busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_sample",  a_sample,  0);
        check("arst_sum_ed",  a_sum_ed,  0);
        check("arst_max_ed",  a_max_ed,  0);
        check("arst_sum_red", a_sum_red, 0);
        check("arst_busy",    a_busy,    0);
        check("arst_ready",   a_ready,   1);
        @(negedge clk);
        rst = 1'b0;
        send(0, 9'd10, 9'd10, 17'd100, lat);
        check("post_arst_latency", lat,      2);
        check("post_arst_sample",  a_sample, 1);
        check("post_arst_sum_red", a_sum_red, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
